ysyx_22040729_rf_wb_scheduler: RTL and testbench

//  Write-back scheduler for the integer register file (REGI_DEPTH x DATA_WIDTH, 1 write port, x0 hard-zero).

---
 rtl/ysyx_22040729_rf_wb_scheduler_if.sv | 41 ++++
 rtl/ysyx_22040729_rf_wb_scheduler.sv | 102 ++++++++++
 tb/tb_ysyx_22040729_rf_wb_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040729_rf_wb_scheduler_if.sv
// Write-back bundle between the ALU/LSU write-back stages, decode, and the RF write port.
// Decode and the requesters drive the master side, and the scheduler sits on the slave side.
interface ysyx_22040729_rf_wb_scheduler_if #(
  parameter int AW = 5,
  parameter int DW = 64
);
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_waddr;
  logic [DW-1:0] lsu_wdata;
  logic          iss_valid;
  logic          iss_ready;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic          raw_stall;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          err;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  alu_ready, lsu_ready, iss_ready, raw_stall,
    input  rf_wen, rf_waddr, rf_wdata, err
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2,
    output alu_ready, lsu_ready, iss_ready, raw_stall,
    output rf_wen, rf_waddr, rf_wdata, err
  );
endinterface

// File: rtl/ysyx_22040729_rf_wb_scheduler.sv
// Round-robin ALU/LSU arbiter for the single RF write port, plus a per-register
// pending-write scoreboard that decode queries for RAW/WAW stalls.
module ysyx_22040729_rf_wb_scheduler #(
  parameter  int REGI_DEPTH = 32,
  parameter  int DATA_WIDTH = 64,
  localparam int AW         = $clog2(REGI_DEPTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  ysyx_22040729_rf_wb_scheduler_if.slave      wb_io
);

  logic                  alu_gnt, lsu_gnt, any_gnt;
  logic                  prio_lsu_q, prio_lsu_d;
  logic [AW-1:0]         gnt_waddr;
  logic [DATA_WIDTH-1:0] gnt_wdata;

  logic                  rf_wen_q, rf_wen_d;
  logic [AW-1:0]         rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [1:0]            cnt_q [REGI_DEPTH];
  logic [1:0]            cnt_d [REGI_DEPTH];
  logic                  err_q, err_d;
  logic                  iss_ready, iss_fire;

  // prio_lsu_q set means the LSU wins the next contested cycle.
  always_comb begin
    alu_gnt    = wb_io.alu_valid & (~wb_io.lsu_valid | ~prio_lsu_q);
    lsu_gnt    = wb_io.lsu_valid & (~wb_io.alu_valid |  prio_lsu_q);
    any_gnt    = alu_gnt | lsu_gnt;
    gnt_waddr  = alu_gnt ? wb_io.alu_waddr : wb_io.lsu_waddr;
    gnt_wdata  = alu_gnt ? wb_io.alu_wdata : wb_io.lsu_wdata;
    prio_lsu_d = prio_lsu_q;
    if (alu_gnt) begin
      prio_lsu_d = 1'b1;
    end else if (lsu_gnt) begin
      prio_lsu_d = 1'b0;
    end
    rf_wen_d   = any_gnt && (gnt_waddr != '0);
    rf_waddr_d = any_gnt ? gnt_waddr : rf_waddr_q;
    rf_wdata_d = any_gnt ? gnt_wdata : rf_wdata_q;
  end

  assign iss_ready = (cnt_q[wb_io.iss_rd] != 2'd3);
  assign iss_fire  = wb_io.iss_valid && iss_ready && (wb_io.iss_rd != '0);

  // A retirement and an issue to the same register cancel; retiring a zero count flags err.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < REGI_DEPTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = 2'd0;
      end else begin
        case ({iss_fire && (wb_io.iss_rd == AW'(i)), rf_wen_q && (rf_waddr_q == AW'(i))})
          2'b10: cnt_d[i] = cnt_q[i] + 2'd1;
          2'b01: begin
            if (cnt_q[i] == 2'd0) begin
              err_d = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - 2'd1;
            end
          end
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_lsu_q <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < REGI_DEPTH; i++) begin
        cnt_q[i] <= 2'd0;
      end
    end else begin
      prio_lsu_q <= prio_lsu_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
      for (int i = 0; i < REGI_DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign wb_io.alu_ready = alu_gnt;
  assign wb_io.lsu_ready = lsu_gnt;
  assign wb_io.iss_ready = iss_ready;
  assign wb_io.raw_stall = (cnt_q[wb_io.chk_rs1] != 2'd0) | (cnt_q[wb_io.chk_rs2] != 2'd0);
  assign wb_io.rf_wen    = rf_wen_q;
  assign wb_io.rf_waddr  = rf_waddr_q;
  assign wb_io.rf_wdata  = rf_wdata_q;
  assign wb_io.err       = err_q;

endmodule

// File: tb/tb_ysyx_22040729_rf_wb_scheduler.sv
// Directed bench for the write-back scheduler: arbitration, write path, scoreboard, err, async reset.
module tb_ysyx_22040729_rf_wb_scheduler;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  ysyx_22040729_rf_wb_scheduler_if #(.AW(5), .DW(64)) wb_if ();

  ysyx_22040729_rf_wb_scheduler #(.REGI_DEPTH(32), .DATA_WIDTH(64)) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wb_io  (wb_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    wb_if.alu_valid = 1'b0; wb_if.alu_waddr = '0; wb_if.alu_wdata = '0;
    wb_if.lsu_valid = 1'b0; wb_if.lsu_waddr = '0; wb_if.lsu_wdata = '0;
    wb_if.iss_valid = 1'b0; wb_if.iss_rd    = '0;
    wb_if.chk_rs1   = '0;   wb_if.chk_rs2   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_alu [4];
    exp_alu[0] = 2'b10; exp_alu[1] = 2'b01; exp_alu[2] = 2'b10; exp_alu[3] = 2'b01;

    // reset state
    do_reset();
    #1;
    check("rst_rf_wen",   64'(wb_if.rf_wen),    64'd0);
    check("rst_rf_waddr", 64'(wb_if.rf_waddr),  64'd0);
    check("rst_rf_wdata", wb_if.rf_wdata,       64'd0);
    check("rst_err",      64'(wb_if.err),       64'd0);
    check("rst_stall",    64'(wb_if.raw_stall), 64'd0);
    check("rst_iss_rdy",  64'(wb_if.iss_ready), 64'd1);

    // single ALU request: same-cycle ready, one-cycle write latency
    wb_if.alu_valid = 1'b1; wb_if.alu_waddr = 5'd5; wb_if.alu_wdata = 64'h1234;
    #1;
    check("t2_alu_ready", 64'(wb_if.alu_ready), 64'd1);
    check("t2_lsu_ready", 64'(wb_if.lsu_ready), 64'd0);
    step();
    check("t2_rf_wen",   64'(wb_if.rf_wen),   64'd1);
    check("t2_rf_waddr", 64'(wb_if.rf_waddr), 64'd5);
    check("t2_rf_wdata", wb_if.rf_wdata,      64'h1234);

    // both valid from reset: ALU, LSU, ALU, LSU
    do_reset();
    wb_if.alu_valid = 1'b1; wb_if.alu_waddr = 5'd1; wb_if.alu_wdata = 64'hAAAA;
    wb_if.lsu_valid = 1'b1; wb_if.lsu_waddr = 5'd2; wb_if.lsu_wdata = 64'hBBBB;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("t3_ready_%0d", c), 64'({wb_if.alu_ready, wb_if.lsu_ready}), 64'(exp_alu[c]));
      step();
      check($sformatf("t3_wen_%0d", c),   64'(wb_if.rf_wen),   64'd1);
      check($sformatf("t3_waddr_%0d", c), 64'(wb_if.rf_waddr), (c % 2 == 0) ? 64'd1 : 64'd2);
      check($sformatf("t3_wdata_%0d", c), wb_if.rf_wdata,      (c % 2 == 0) ? 64'hAAAA : 64'hBBBB);
    end

    // issue rd=7 three times, saturate, then retire three writes
    do_reset();
    wb_if.iss_valid = 1'b1; wb_if.iss_rd = 5'd7; wb_if.chk_rs1 = 5'd7;
    #1;
    check("t4_iss_rdy0", 64'(wb_if.iss_ready), 64'd1);
    check("t4_stall0",   64'(wb_if.raw_stall), 64'd0);
    step();
    check("t4_stall1", 64'(wb_if.raw_stall), 64'd1);
    step();
    step();
    #1;
    check("t4_iss_sat", 64'(wb_if.iss_ready), 64'd0);
    wb_if.iss_rd = 5'd0;
    #1;
    check("t4_iss_x0", 64'(wb_if.iss_ready), 64'd1);
    wb_if.iss_valid = 1'b0; wb_if.iss_rd = 5'd7;
    wb_if.alu_valid = 1'b1; wb_if.alu_waddr = 5'd7; wb_if.alu_wdata = 64'h77;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t4_stall_ret%0d", c), 64'(wb_if.raw_stall), 64'd1);
    end
    wb_if.alu_valid = 1'b0;
    step();
    check("t4_stall_clear", 64'(wb_if.raw_stall), 64'd0);
    check("t4_iss_rdy_back", 64'(wb_if.iss_ready), 64'd1);
    check("t4_err", 64'(wb_if.err), 64'd0);

    // same-cycle issue and retire on reg 9 leaves the count at 1
    wb_if.iss_valid = 1'b1; wb_if.iss_rd = 5'd9; wb_if.chk_rs1 = 5'd9;
    step();
    wb_if.iss_valid = 1'b0;
    wb_if.alu_valid = 1'b1; wb_if.alu_waddr = 5'd9; wb_if.alu_wdata = 64'h99;
    step();
    check("t5_wen", 64'(wb_if.rf_wen), 64'd1);
    wb_if.alu_valid = 1'b0;
    wb_if.iss_valid = 1'b1;
    step();
    check("t5_stall_hold", 64'(wb_if.raw_stall), 64'd1);
    check("t5_err", 64'(wb_if.err), 64'd0);
    wb_if.iss_valid = 1'b0;
    wb_if.alu_valid = 1'b1;
    step();
    wb_if.alu_valid = 1'b0;
    step();
    check("t5_stall_clear", 64'(wb_if.raw_stall), 64'd0);
    check("t5_err_after", 64'(wb_if.err), 64'd0);

    // LSU write to x0, then unmatched write to reg 3
    wb_if.chk_rs1 = 5'd3;
    wb_if.lsu_valid = 1'b1; wb_if.lsu_waddr = 5'd0; wb_if.lsu_wdata = 64'hDEAD;
    #1;
    check("t6_lsu_ready", 64'(wb_if.lsu_ready), 64'd1);
    step();
    check("t6_x0_wen",   64'(wb_if.rf_wen),   64'd0);
    check("t6_x0_waddr", 64'(wb_if.rf_waddr), 64'd0);
    wb_if.lsu_waddr = 5'd3; wb_if.lsu_wdata = 64'h33;
    step();
    check("t6_x0_err",    64'(wb_if.err),      64'd0);
    check("t6_r3_wen",    64'(wb_if.rf_wen),   64'd1);
    check("t6_r3_waddr",  64'(wb_if.rf_waddr), 64'd3);
    check("t6_r3_wdata",  wb_if.rf_wdata,      64'h33);
    wb_if.lsu_valid = 1'b0;
    step();
    check("t6_err_set",   64'(wb_if.err),       64'd1);
    check("t6_stall_r3",  64'(wb_if.raw_stall), 64'd0);
    step();
    step();
    check("t6_err_sticky", 64'(wb_if.err), 64'd1);

    // asynchronous reset in the middle of traffic
    wb_if.iss_valid = 1'b1; wb_if.iss_rd = 5'd4; wb_if.chk_rs1 = 5'd4;
    wb_if.alu_valid = 1'b1; wb_if.alu_waddr = 5'd4; wb_if.alu_wdata = 64'h44;
    step();
    check("t1_pre_wen",   64'(wb_if.rf_wen),    64'd1);
    check("t1_pre_stall", 64'(wb_if.raw_stall), 64'd1);
    check("t1_pre_err",   64'(wb_if.err),       64'd1);
    rst_ni = 1'b0;
    #1;
    check("t1_async_wen",   64'(wb_if.rf_wen),    64'd0);
    check("t1_async_err",   64'(wb_if.err),       64'd0);
    check("t1_async_stall", 64'(wb_if.raw_stall), 64'd0);
    idle_inputs();
    step();
    rst_ni = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
